trace_capture_buffer: RTL and testbench
=======================================

// Module: trace_capture_buffer
// PURPOSE
//  Synthesizable on-chip execution trace buffer for the Computer (CPU + ROM + RAM).
//  Records one entry per retired instruction: PC, instruction word and any RAM write.
//  Entries go into a circular buffer; a programmable trigger fires, then a post-trigger count runs.
//  Readout is oldest-first over a valid/ready stream, so a bench or debug UART can dump the window.
// PARAMETERS
//  ADDR_W   16  PC and RAM address width
//  DATA_W   16  RAM data width
//  INSTR_W  16  instruction word width
//  DEPTH    32  entries in the buffer; power of 2, >=4
//  CNT_W    $clog2(DEPTH)+1  width of post_len and counters (localparam)
//  ENTRY_W  1+2*ADDR_W+DATA_W+INSTR_W  entry = {mem_write,mem_addr,mem_data,instr,pc} (localparam)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst        in   1        synchronous reset, active-low (rst==0 at posedge clk resets)
//  arm        in   1        one-cycle pulse; starts a new capture
//  retire     in   1        one-cycle strobe per completed instruction; capture qualifier
//  pc         in   ADDR_W   PC of retiring instruction
//  instr      in   INSTR_W  retiring instruction word
//  mem_write  in   1        RAM write enable during the retiring instruction
//  mem_addr   in   ADDR_W   RAM address
//  mem_data   in   DATA_W   RAM write data
//  trig_mode  in   2        0=PC match, 1=RAM-write addr match, 2=retire count, 3=immediate
//  trig_value in   ADDR_W   match value (PC, address or retire index)
//  post_len   in   CNT_W    entries captured after the trigger entry; clamped to DEPTH-1
//  rd_ready   in   1        consumer accepts rd_data
//  rd_valid   out  1        rd_data holds a valid entry
//  rd_data    out  ENTRY_W  entry being read, oldest first
//  rd_last    out  1        high with the final entry of the dump
//  armed      out  1        state is ARMED or POST
//  triggered  out  1        trigger seen since last arm
//  wrapped    out  1        buffer overwrote old entries (>=DEPTH writes since arm)
// BEHAVIOUR
//  Reset: state=IDLE; rd_valid,rd_last,armed,triggered,wrapped=0; rd_data=0; pointers/counters=0.
//  States: IDLE -> ARMED -> POST -> DUMP -> IDLE.
//  IDLE: arm -> ARMED; clears wr_ptr, retire_cnt, wrapped, triggered. retire ignored.
//  ARMED: each retire writes entry at wr_ptr, wr_ptr+1 mod DEPTH; wrapped set when wr_ptr wraps to 0.
//   Trigger is evaluated on the same retire as its capture:
//   mode0 pc==trig_value; mode1 mem_write && mem_addr==trig_value;
//   mode2 retire_cnt==trig_value (0-based, counted since arm); mode3 first retire.
//   On trigger: triggered=1, post_rem=min(post_len,DEPTH-1); ->POST, or ->DUMP next cycle if post_rem==0.
//  POST: each retire captures an entry and decrements post_rem; the retire taking it to 0 -> DUMP.
//  DUMP: rd_ptr = wrapped ? wr_ptr : 0; count = wrapped ? DEPTH : wr_ptr (never 0).
//   rd_valid rises first cycle of DUMP. rd_data/rd_last hold stable while rd_valid && !rd_ready.
//   Transfer on rd_valid&&rd_ready; next entry presented the following cycle (1/cycle throughput).
//   rd_last=1 on the final entry; its transfer -> IDLE, rd_valid=0; triggered/wrapped hold until next arm.
//  RAM read latency 1: prefetch the next entry so back-to-back ready sustains full rate.
//  arm in ARMED/POST restarts capture (same as arm in IDLE); arm in DUMP is ignored.
//  retire in DUMP is ignored (capture frozen).
//  trig_mode, trig_value, post_len are sampled every cycle; hold them constant while armed.
//  Counter widths: retire_cnt saturates at 2^ADDR_W-1; no wrap in mode2.
//  rst low at any time, mid-capture or mid-dump, forces reset state next edge; RAM contents not cleared.
// STRUCTURE
//  trace_defs.vh: state encodings (ST_IDLE, ST_ARMED, ST_POST, ST_DUMP); TRIG_PC, TRIG_MEMW,
//   TRIG_COUNT, TRIG_NOW; entry field offsets.
//  Sub-module trace_ram: DEPTH x ENTRY_W simple dual-port, 1 write port, registered read port.
//  Top: FSM, trigger compare, pointers, post counter, readout skid/hold logic.
// TESTING (DEPTH=8)
//  T1 mode3, post_len=3, 4 retires pc=0..3 -> dump 4 entries pc 0,1,2,3; rd_last on pc=3; wrapped=0.
//  T2 mode0 trig_value=12, post_len=2, pc=0..14 -> wrapped=1; dump 8 entries pc 7..14, rd_last on 14.
//  T3 mode1 trig_value=1, RAM write addr1 data 8 at retire 5 -> trigger entry has mem_write=1,
//     mem_addr=1, mem_data=8.
//  T4 random rd_ready toggling during dump -> rd_data stable while stalled; 8 entries in order, no loss.
//  T5 rst low mid-POST -> next cycle all outputs 0, state IDLE; new arm captures cleanly.
//  T6 post_len=15 -> clamped to 7; arm during DUMP ignored, dump completes.

Source files
------------

// File: rtl/trace_capture_buffer_pkg.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer_pkg
//   Shared definitions for the execution trace buffer: capture FSM state
//   encoding and trigger-mode codes. Entry layout (MSB..LSB) is
//   {mem_write, mem_addr, mem_data, instr, pc}.
// -----------------------------------------------------------------------------
package trace_capture_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    localparam logic [1:0] TRIG_PC    = 2'd0;
    localparam logic [1:0] TRIG_MEMW  = 2'd1;
    localparam logic [1:0] TRIG_COUNT = 2'd2;
    localparam logic [1:0] TRIG_NOW   = 2'd3;

endpackage

// File: rtl/trace_capture_buffer_ram.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer_ram
//   DEPTH x WIDTH simple dual-port storage: one write port, one registered
//   read port. A read of the address being written in the same cycle returns
//   the new data, so a dump may start on the very cycle of the last capture.
//   Contents are never cleared; only the read register is reset.
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-low reset of the read register
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds when low
//   raddr  in   read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module trace_capture_buffer_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 65,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port with same-cycle write forwarding
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// trace_capture_buffer
//   On-chip execution trace buffer. Each retired instruction is written into
//   a circular buffer; a programmable trigger starts a post-trigger count,
//   after which the captured window is streamed out oldest-first over a
//   valid/ready interface at one entry per cycle.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   arm                      pulse: start a new capture (ignored while dumping)
//   retire                   strobe per retired instruction
//   pc, instr                retiring instruction PC and word
//   mem_write/addr/data      RAM write performed by that instruction
//   trig_mode, trig_value    trigger selection and match value
//   post_len                 entries captured after the trigger entry
//   rd_ready                 consumer ready
//   rd_valid, rd_data, rd_last   readout stream
//   armed, triggered, wrapped    capture status
// -----------------------------------------------------------------------------
module trace_capture_buffer
    import trace_capture_buffer_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 32,
    localparam int CNT_W   = $clog2(DEPTH) + 1,
    localparam int ENTRY_W = 1 + 2*ADDR_W + DATA_W + INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               retire,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic [1:0]         trig_mode,
    input  logic [ADDR_W-1:0]  trig_value,
    input  logic [CNT_W-1:0]   post_len,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_last,
    output logic               armed,
    output logic               triggered,
    output logic               wrapped
);

    localparam int PTR_W = $clog2(DEPTH);

    state_t             state_r, state_nxt_s;
    logic               restart_s, cap_s, go_dump_s, trig_hit_s, xfer_s;
    logic               wrap_now_s, wrapped_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_inc_s, first_ptr_s, rd_ptr_r, ram_raddr_s;
    logic [ADDR_W-1:0]  retire_cnt_r;
    logic [CNT_W-1:0]   post_rem_r, post_clamp_s, dump_cnt_s, dump_rem_r;
    logic [ENTRY_W-1:0] entry_s;
    logic               ram_we_s, ram_re_s;
    logic               rd_valid_r, rd_last_r, armed_r, triggered_r, wrapped_r;

    assign entry_s       = {mem_write, mem_addr, mem_data, instr, pc};
    assign xfer_s        = rd_valid_r & rd_ready;
    assign wr_ptr_inc_s  = wr_ptr_r + PTR_W'(1);
    assign wrap_now_s    = (wr_ptr_r == PTR_W'(DEPTH - 1));
    assign wrapped_nxt_s = wrapped_r | wrap_now_s;
    // Oldest entry and entry count as they will be after the capture that
    // ends the window (all transitions into DUMP happen on a capture cycle).
    assign first_ptr_s   = wrapped_nxt_s ? wr_ptr_inc_s : PTR_W'(0);
    assign dump_cnt_s    = wrapped_nxt_s ? CNT_W'(DEPTH) : {1'b0, wr_ptr_inc_s};
    assign post_clamp_s  = (post_len > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_len;
    assign ram_we_s      = cap_s & rst;

    assign rd_valid  = rd_valid_r;
    assign rd_last   = rd_last_r;
    assign armed     = armed_r;
    assign triggered = triggered_r;
    assign wrapped   = wrapped_r;

    // Trigger compare for the retire currently being captured
    always_comb begin
        trig_hit_s = 1'b0;
        case (trig_mode)
            TRIG_PC:    trig_hit_s = (pc == trig_value);
            TRIG_MEMW:  trig_hit_s = mem_write && (mem_addr == trig_value);
            TRIG_COUNT: trig_hit_s = (retire_cnt_r == trig_value);
            TRIG_NOW:   trig_hit_s = 1'b1;
            default:    trig_hit_s = 1'b0;
        endcase
    end

    // Capture FSM next-state and control strobes; arm wins over retire
    always_comb begin
        state_nxt_s = state_r;
        restart_s   = 1'b0;
        cap_s       = 1'b0;
        go_dump_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (arm) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_ARMED;
                end else if (retire) begin
                    cap_s = 1'b1;
                    if (trig_hit_s && (post_clamp_s == CNT_W'(0))) begin
                        go_dump_s   = 1'b1;
                        state_nxt_s = ST_DUMP;
                    end else if (trig_hit_s) begin
                        state_nxt_s = ST_POST;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_POST: begin
                if (arm) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_ARMED;
                end else if (retire) begin
                    cap_s = 1'b1;
                    if (post_rem_r <= CNT_W'(1)) begin
                        go_dump_s   = 1'b1;
                        state_nxt_s = ST_DUMP;
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end else begin
                    state_nxt_s = ST_POST;
                end
            end
            ST_DUMP: begin
                if (xfer_s && rd_last_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DUMP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered armed flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            armed_r <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_POST);
        end
    end

    // Write pointer, retire counter, trigger and post-trigger bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r     <= '0;
            retire_cnt_r <= '0;
            post_rem_r   <= '0;
            triggered_r  <= 1'b0;
            wrapped_r    <= 1'b0;
        end else if (restart_s) begin
            wr_ptr_r     <= '0;
            retire_cnt_r <= '0;
            post_rem_r   <= '0;
            triggered_r  <= 1'b0;
            wrapped_r    <= 1'b0;
        end else if (cap_s) begin
            wr_ptr_r  <= wr_ptr_inc_s;
            wrapped_r <= wrapped_nxt_s;
            if (state_r == ST_ARMED) begin
                // Saturate so a large count never aliases back onto trig_value
                if (retire_cnt_r != {ADDR_W{1'b1}}) begin
                    retire_cnt_r <= retire_cnt_r + ADDR_W'(1);
                end
                if (trig_hit_s) begin
                    triggered_r <= 1'b1;
                    post_rem_r  <= post_clamp_s;
                end
            end else begin
                post_rem_r <= post_rem_r - CNT_W'(1);
            end
        end
    end

    // Read address: first entry on dump entry, then one ahead of the
    // presented entry on every transfer so the RAM register refills in time
    always_comb begin
        ram_re_s    = 1'b0;
        ram_raddr_s = rd_ptr_r + PTR_W'(1);
        if (go_dump_s) begin
            ram_re_s    = 1'b1;
            ram_raddr_s = first_ptr_s;
        end else if ((state_r == ST_DUMP) && xfer_s && !rd_last_r) begin
            ram_re_s = 1'b1;
        end else begin
            ram_re_s = 1'b0;
        end
    end

    // Readout stream control: valid, last flag, presented pointer, remaining count
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_ptr_r   <= '0;
            dump_rem_r <= '0;
        end else if (go_dump_s) begin
            rd_valid_r <= 1'b1;
            rd_last_r  <= (dump_cnt_s == CNT_W'(1));
            rd_ptr_r   <= first_ptr_s;
            dump_rem_r <= dump_cnt_s;
        end else if ((state_r == ST_DUMP) && xfer_s) begin
            if (rd_last_r) begin
                rd_valid_r <= 1'b0;
                rd_last_r  <= 1'b0;
            end else begin
                rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                dump_rem_r <= dump_rem_r - CNT_W'(1);
                rd_last_r  <= (dump_rem_r == CNT_W'(2));
            end
        end
    end

    trace_capture_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (entry_s),
        .re    (ram_re_s),
        .raddr (ram_raddr_s),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_trace_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_trace_capture_buffer
//   Directed bench for trace_capture_buffer with DEPTH=8. A queue-based model
//   keeps every entry captured since arm and, when the window closes, the
//   expected dump is simply the last min(N, DEPTH) entries. Outputs are
//   compared against the model on every falling edge; directed tests also
//   pin the dumped PCs to hand-written values.
// -----------------------------------------------------------------------------
module tb_trace_capture_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int EW    = 65;

    logic          clk = 1'b0;
    logic          rst, arm, retire, mem_write, rd_ready;
    logic [15:0]   pc, instr, mem_addr, mem_data, trig_value;
    logic [1:0]    trig_mode;
    logic [CNT_W-1:0] post_len;
    logic          rd_valid, rd_last, armed, triggered, wrapped;
    logic [EW-1:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    trace_capture_buffer #(
        .ADDR_W(16), .DATA_W(16), .INSTR_W(16), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .retire(retire), .pc(pc), .instr(instr),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .trig_mode(trig_mode), .trig_value(trig_value), .post_len(post_len),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .armed(armed), .triggered(triggered), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic mw, input logic [15:0] ma,
                                         input logic [15:0] md, input logic [15:0] ins,
                                         input logic [15:0] p);
        return {mw, ma, md, ins, p};
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 dumping
    int            m_phase = 0;
    bit            m_trig  = 1'b0;
    int            m_post  = 0;
    logic [EW-1:0] log_q[$];
    logic [EW-1:0] dq[$];

    function automatic void m_start();
        m_phase = 1;
        m_trig  = 1'b0;
        log_q.delete();
    endfunction

    function automatic void m_dump();
        int n;
        n = (log_q.size() < DEPTH) ? log_q.size() : DEPTH;
        dq.delete();
        for (int k = log_q.size() - n; k < log_q.size(); k++) dq.push_back(log_q[k]);
        m_phase = 3;
    endfunction

    always @(posedge clk) begin
        bit hit;
        if (!rst) begin
            m_phase = 0; m_trig = 1'b0; m_post = 0;
            log_q.delete(); dq.delete();
        end else begin
            case (m_phase)
                0: if (arm) m_start();
                1, 2: begin
                    if (arm) m_start();
                    else if (retire) begin
                        hit = 1'b0;
                        if (m_phase == 1) begin
                            case (trig_mode)
                                2'd0: hit = (pc == trig_value);
                                2'd1: hit = mem_write && (mem_addr == trig_value);
                                2'd2: hit = (log_q.size() == int'(trig_value));
                                default: hit = 1'b1;
                            endcase
                        end
                        log_q.push_back(mk(mem_write, mem_addr, mem_data, instr, pc));
                        if (hit) begin
                            m_trig = 1'b1;
                            m_post = (int'(post_len) > DEPTH - 1) ? DEPTH - 1 : int'(post_len);
                            if (m_post == 0) m_dump(); else m_phase = 2;
                        end else if (m_phase == 2) begin
                            m_post--;
                            if (m_post == 0) m_dump();
                        end
                    end
                end
                default: begin
                    if (rd_ready) void'(dq.pop_front());
                    if (dq.size() == 0) m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    bit            checking   = 1'b0;
    bit            prev_stall = 1'b0;
    logic [EW-1:0] prev_data;
    logic [EW-1:0] got_q[$];
    logic [15:0]   last_pc;

    always @(negedge clk) begin
        if (checking) begin
            chk("armed", armed, (m_phase == 1) || (m_phase == 2));
            chk("triggered", triggered, m_trig);
            chk("wrapped", wrapped, log_q.size() >= DEPTH);
            chk("rd_valid", rd_valid, m_phase == 3);
            if (m_phase == 3) begin
                chk("rd_data", rd_data, dq[0]);
                chk("rd_last", rd_last, dq.size() == 1);
            end else begin
                chk("rd_last_idle", rd_last, 1'b0);
            end
            if (prev_stall) begin
                chk("hold_valid", rd_valid, 1'b1);
                chk("hold_data", rd_data, prev_data);
            end
            if (rd_valid === 1'b1 && rd_ready) begin
                got_q.push_back(rd_data);
                if (rd_last === 1'b1) last_pc = rd_data[15:0];
            end
            prev_stall = (rd_valid === 1'b1) && !rd_ready;
            prev_data  = rd_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        got_q.delete();
        last_pc = 16'hffff;
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic ret(input logic [15:0] p, input logic mw, input logic [15:0] ma,
                       input logic [15:0] md);
        retire = 1'b1; pc = p; instr = p ^ 16'h5a00;
        mem_write = mw; mem_addr = ma; mem_data = md;
        tick();
        retire = 1'b0; mem_write = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((rd_valid === 1'b1 || m_phase == 3) && n < 200) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        rd_ready = 1'b1;
        chk("drain_bound", n < 200, 1'b1);
        chk("drain_valid_low", rd_valid, 1'b0);
    endtask

    task automatic pcs(input string nm, input int cnt, input logic [15:0] base,
                       input logic [15:0] lastp);
        chk({nm, "_count"}, got_q.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < got_q.size()) chk({nm, "_pc"}, got_q[i][15:0], base + 16'(i));
        end
        chk({nm, "_last_pc"}, last_pc, lastp);
    endtask

    initial begin
        rst = 1'b0; arm = 1'b0; retire = 1'b0; rd_ready = 1'b1;
        pc = '0; instr = '0; mem_write = 1'b0; mem_addr = '0; mem_data = '0;
        trig_mode = 2'd0; trig_value = '0; post_len = '0;
        tick(); tick();
        checking = 1'b1;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 65'd0);
        chk("rst_armed", armed, 1'b0);
        rst = 1'b1;
        tick();

        // T1: immediate trigger, post_len 3
        trig_mode = 2'd3; post_len = 4'd3;
        arm_pulse();
        for (int i = 0; i < 4; i++) ret(16'(i), 1'b0, 16'h0, 16'h0);
        drain(1'b0);
        pcs("t1", 4, 16'd0, 16'd3);
        chk("t1_wrapped", wrapped, 1'b0);

        // T2: PC match at 12, post 2, buffer wraps
        trig_mode = 2'd0; trig_value = 16'd12; post_len = 4'd2;
        arm_pulse();
        for (int i = 0; i < 15; i++) ret(16'(i), 1'b0, 16'h0, 16'h0);
        drain(1'b0);
        pcs("t2", 8, 16'd7, 16'd14);
        chk("t2_wrapped", wrapped, 1'b1);

        // T3: RAM-write address match; an unqualified address match comes first
        trig_mode = 2'd1; trig_value = 16'd1; post_len = 4'd2;
        arm_pulse();
        for (int i = 0; i < 8; i++)
            ret(16'h0200 + 16'(i), i == 5, (i == 3 || i == 5) ? 16'd1 : 16'd9, 16'd8);
        drain(1'b0);
        pcs("t3", 8, 16'h0200, 16'h0207);
        if (got_q.size() > 5) begin
            chk("t3_trig_mw", got_q[5][64], 1'b1);
            chk("t3_trig_addr", got_q[5][63:48], 16'd1);
            chk("t3_trig_data", got_q[5][47:32], 16'd8);
        end

        // T4: retire-count trigger at index 3, post 4, random backpressure
        trig_mode = 2'd2; trig_value = 16'd3; post_len = 4'd4;
        arm_pulse();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) ret(16'd100 + 16'(i), 1'b0, 16'h0, 16'h0);
        tick(); tick(); tick();
        drain(1'b1);
        pcs("t4", 8, 16'd100, 16'd107);

        // T5: reset in the middle of the post-trigger phase
        trig_mode = 2'd3; post_len = 4'd5;
        arm_pulse();
        ret(16'd40, 1'b0, 16'h0, 16'h0);
        ret(16'd41, 1'b0, 16'h0, 16'h0);
        chk("t5_armed_before", armed, 1'b1);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("t5_armed", armed, 1'b0);
        chk("t5_triggered", triggered, 1'b0);
        chk("t5_rd_data", rd_data, 65'd0);
        post_len = 4'd1;
        arm_pulse();
        ret(16'd50, 1'b0, 16'h0, 16'h0);
        ret(16'd51, 1'b0, 16'h0, 16'h0);
        drain(1'b0);
        pcs("t5", 2, 16'd50, 16'd51);

        // T6: post_len clamp, arm and retire ignored during the dump
        trig_mode = 2'd3; post_len = 4'd15;
        arm_pulse();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) ret(16'd200 + 16'(i), 1'b0, 16'h0, 16'h0);
        arm = 1'b1; tick(); arm = 1'b0;
        ret(16'd208, 1'b0, 16'h0, 16'h0);
        chk("t6_armed_in_dump", armed, 1'b0);
        drain(1'b0);
        pcs("t6", 8, 16'd200, 16'd207);
        chk("t6_triggered", triggered, 1'b1);

        // T7: single-entry window read on the same cycle it is written
        trig_mode = 2'd3; post_len = 4'd0;
        arm_pulse();
        ret(16'd77, 1'b1, 16'h0033, 16'hbeef);
        drain(1'b0);
        pcs("t7", 1, 16'd77, 16'd77);
        if (got_q.size() > 0) chk("t7_entry", got_q[0], {1'b1, 16'h0033, 16'hbeef, 16'h5a4d, 16'd77});

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
